// File: rtl/processing_array_pipe.sv
// Broadcast ARRAY_SIZE-lane processing array: pass/scale/offset/accumulate per beat, wrap or saturate.
// Latency: S1 captures the beat on the accepting edge, S2 presents the lane results one edge later.
// Backpressure: S2 holds while out_ready is low, S1 fills behind it, then in_ready drops (2 beats held).
// Ports: clk/rst (async active-high); data_in/mode/in_valid/in_ready: input beat handshake;
//        clear_acc: synchronous clear of accumulators and ovf; data_out/out_valid/out_ready:
//        per-lane result handshake (lane i at data_out[i]); ovf: sticky per-lane overflow flags.
module processing_array_pipe #(
   parameter int ARRAY_SIZE = 4,
   parameter int DATA_WIDTH = 8,
   parameter int SATURATE   = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [DATA_WIDTH-1:0]                 data_in,
   input  logic [1:0]                            mode,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic                                  clear_acc,
   output logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] data_out,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ARRAY_SIZE-1:0]                 ovf
);

   // Wide enough for acc + data_in*ARRAY_SIZE without loss.
   localparam int IW = DATA_WIDTH + $clog2(ARRAY_SIZE + 1) + 1;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_SCALE  = 2'd1;
   localparam logic [1:0] MODE_OFFSET = 2'd2;
   localparam logic [1:0] MODE_ACCUM  = 2'd3;

   typedef struct packed {
      logic [1:0]            mode;
      logic [DATA_WIDTH-1:0] dat;
   } beat_t;

   beat_t                                 s1_dat;
   logic                                  s1_vld;
   logic                                  s2_adv;
   logic                                  s1_move;

   logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] acc;
   logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] acc_nxt;
   logic [ARRAY_SIZE-1:0][DATA_WIDTH-1:0] res;
   logic [ARRAY_SIZE-1:0]                 over;
   logic [ARRAY_SIZE-1:0]                 ovf_nxt;
   logic [IW-1:0]                         prod [ARRAY_SIZE];
   logic [IW-1:0]                         acc_base [ARRAY_SIZE];
   logic [IW-1:0]                         full [ARRAY_SIZE];

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !s1_vld || s2_adv;
   assign s1_move  = s1_vld && s2_adv;

   always_comb begin
      for (int i = 0; i < ARRAY_SIZE; i++) begin
         prod[i] = IW'(s1_dat.dat) * IW'(i + 1);
         // A coincident clear means the accumulating beat starts from zero.
         acc_base[i] = clear_acc ? '0 : IW'(acc[i]);
         case (s1_dat.mode)
            MODE_PASS:   full[i] = IW'(s1_dat.dat);
            MODE_SCALE:  full[i] = prod[i];
            MODE_OFFSET: full[i] = IW'(s1_dat.dat) + IW'(i + 1);
            default:     full[i] = acc_base[i] + prod[i];
         endcase
         over[i] = |full[i][IW-1:DATA_WIDTH];
         res[i]  = (over[i] && (SATURATE != 0)) ? '1 : full[i][DATA_WIDTH-1:0];

         acc_nxt[i] = clear_acc ? '0 : acc[i];
         ovf_nxt[i] = clear_acc ? 1'b0 : ovf[i];
         if (s1_move) begin
            if (over[i]) ovf_nxt[i] = 1'b1;
            if (s1_dat.mode == MODE_ACCUM) acc_nxt[i] = res[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_dat    <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
         acc       <= '0;
         ovf       <= '0;
      end else begin
         if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) s1_dat <= '{mode: mode, dat: data_in};
         end
         if (s2_adv) out_valid <= s1_vld;
         if (s1_move) data_out <= res;
         acc <= acc_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_processing_array_pipe.sv
// Bench for processing_array_pipe: wrap and saturate instances driven in lockstep.
// Expected lane results come from a behavioural model computed at beat acceptance.
// Output handshake is sampled on the falling edge and checked against per-instance queues.
module tb_processing_array_pipe;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      data_in;
   logic [1:0]      mode;
   logic            in_valid;
   logic            clear_acc;
   logic            out_ready;

   logic            in_ready0, in_ready1;
   logic [3:0][7:0] do0, do1;
   logic            ov0, ov1;
   logic [3:0]      ovf0, ovf1;

   int n_chk  = 0;
   int n_fail = 0;

   logic [35:0] q0 [$];
   logic [35:0] q1 [$];
   int          macc0 [4];
   int          macc1 [4];
   logic [3:0]  movf0, movf1;

   always #5 clk = ~clk;

   processing_array_pipe #(.ARRAY_SIZE(4), .DATA_WIDTH(8), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready0), .clear_acc(clear_acc), .data_out(do0), .out_valid(ov0),
      .out_ready(out_ready), .ovf(ovf0));

   processing_array_pipe #(.ARRAY_SIZE(4), .DATA_WIDTH(8), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .in_valid(in_valid),
      .in_ready(in_ready1), .clear_acc(clear_acc), .data_out(do1), .out_valid(ov1),
      .out_ready(out_ready), .ovf(ovf1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         macc0[i] = 0;
         macc1[i] = 0;
      end
      movf0 = '0;
      movf1 = '0;
   endtask

   task automatic model(input logic [7:0] d, input logic [1:0] m, input bit clr);
      logic [31:0] r0, r1;
      int k, f0, f1;
      if (clr) model_reset();
      r0 = '0;
      r1 = '0;
      for (int i = 0; i < 4; i++) begin
         k = i + 1;
         case (m)
            2'd0:    begin f0 = int'(d);            f1 = int'(d);            end
            2'd1:    begin f0 = int'(d) * k;        f1 = int'(d) * k;        end
            2'd2:    begin f0 = int'(d) + k;        f1 = int'(d) + k;        end
            default: begin f0 = macc0[i] + int'(d) * k; f1 = macc1[i] + int'(d) * k; end
         endcase
         r0[i*8 +: 8] = f0[7:0];
         r1[i*8 +: 8] = (f1 > 255) ? 8'hFF : f1[7:0];
         if (f0 > 255) movf0[i] = 1'b1;
         if (f1 > 255) movf1[i] = 1'b1;
         if (m == 2'd3) begin
            macc0[i] = f0 & 255;
            macc1[i] = (f1 > 255) ? 255 : f1;
         end
      end
      q0.push_back({movf0, r0});
      q1.push_back({movf1, r1});
   endtask

   // Presents one beat and holds it until accepted; optional clear in the cycle it moves to S2.
   task automatic send(input logic [7:0] d, input logic [1:0] m, input bit clr);
      bit acc_ok = 1'b0;
      int t = 0;
      data_in  = d;
      mode     = m;
      in_valid = 1'b1;
      while (!acc_ok && t < 50) begin
         @(negedge clk);
         acc_ok = in_ready0;
         @(posedge clk);
         #1;
         t++;
      end
      in_valid = 1'b0;
      if (!acc_ok) chk("send_timeout", 64'd0, 64'd1);
      else begin
         model(d, m, clr);
         if (clr) begin
            clear_acc = 1'b1;
            @(posedge clk);
            #1;
            clear_acc = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (q0.size() != 0 || q1.size() != 0) chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      clear_acc = 1'b1;
      @(posedge clk);
      #1;
      clear_acc = 1'b0;
      model_reset();
   endtask

   // Output monitor: scoreboard pop on handshake, stability check across stalled cycles.
   initial begin
      logic [35:0] e;
      logic [31:0] last0, last1;
      bit          prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) prev_stall = 1'b0;
         else begin
            if (prev_stall) begin
               chk("stall_vld", {ov1, ov0}, 2'b11);
               chk("stall_dat0", do0, last0);
               chk("stall_dat1", do1, last1);
            end
            if (ov0 && out_ready) begin
               if (q0.size() == 0) chk("sb0_unexpected", {ovf0, do0}, 36'd0 - 36'd1);
               else begin
                  e = q0.pop_front();
                  chk("wrap_out", {ovf0, do0}, e);
               end
            end
            if (ov1 && out_ready) begin
               if (q1.size() == 0) chk("sb1_unexpected", {ovf1, do1}, 36'd0 - 36'd1);
               else begin
                  e = q1.pop_front();
                  chk("sat_out", {ovf1, do1}, e);
               end
            end
            prev_stall = ov0 && !out_ready;
            last0 = do0;
            last1 = do1;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      data_in   = '0;
      mode      = '0;
      in_valid  = 1'b0;
      clear_acc = 1'b0;
      out_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {ov1, ov0}, 2'b00);
      chk("rst_data_out", {do1, do0}, 64'd0);
      chk("rst_ovf", {ovf1, ovf0}, 8'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {in_ready1, in_ready0}, 2'b11);

      // PASS latency: result visible after the second edge following presentation.
      @(posedge clk);
      #1;
      send(8'h20, 2'd0, 1'b0);
      @(negedge clk);
      chk("lat_edge1", ov0, 1'b0);
      @(negedge clk);
      chk("lat_edge2", ov0, 1'b1);
      drain();

      // SCALE with overflow on the last lane.
      send(8'h50, 2'd1, 1'b0);
      drain();
      chk("scale_ovf_wrap", ovf0, 4'b1000);
      chk("scale_ovf_sat", ovf1, 4'b1000);

      // ACCUM sequence, then clear coincident with a new ACCUM beat.
      clear();
      chk("clear_ovf", {ovf1, ovf0}, 8'd0);
      send(8'h10, 2'd3, 1'b0);
      send(8'h20, 2'd3, 1'b0);
      send(8'h30, 2'd3, 1'b0);
      drain();
      send(8'h01, 2'd3, 1'b1);
      drain();
      chk("coinc_clear_ovf", {ovf1, ovf0}, 8'd0);

      // Backpressure: two beats fill the pipe, then in_ready must drop.
      out_ready = 1'b0;
      send(8'h01, 2'd0, 1'b0);
      send(8'h02, 2'd0, 1'b0);
      @(negedge clk);
      chk("full_in_ready", {in_ready1, in_ready0}, 2'b00);
      fork
         begin
            for (int v = 3; v <= 8; v++) send(8'(v), 2'd0, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Stalled ACCUM beat must count once.
      clear();
      out_ready = 1'b0;
      send(8'h10, 2'd3, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      // Reset with a beat held in S2 and another in S1.
      out_ready = 1'b0;
      send(8'h50, 2'd1, 1'b0);
      send(8'h33, 2'd0, 1'b0);
      @(negedge clk);
      chk("pre_rst_valid", {ov1, ov0}, 2'b11);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {ov1, ov0}, 2'b00);
      chk("midrst_data_out", {do1, do0}, 64'd0);
      chk("midrst_ovf", {ovf1, ovf0}, 8'd0);
      q0.delete();
      q1.delete();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("postrst_in_ready", {in_ready1, in_ready0}, 2'b11);
      @(posedge clk);
      #1;
      send(8'h05, 2'd3, 1'b0);
      drain();

      // Mixed modes back-to-back under random backpressure.
      clear();
      fork
         begin
            for (int n = 0; n < 24; n++) send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 1'b0);
         end
         begin
            repeat (40) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
